// File: rtl/systolic_load_sched.sv
// Per-layer sequencer for the systolic weight/input memory interfaces:
// lower-half weight load, upper-half weight load, input feed, array drain.
module systolic_load_sched #(
    parameter int N_MACS     = 4,
    parameter int FEED_LEN   = 4,
    parameter int DRAIN_CYC  = 6,
    parameter int MAX_LAYERS = 8,
    parameter int TIMEOUT    = 15,
    localparam int NLW = $clog2(MAX_LAYERS + 1),
    localparam int LIW = $clog2(MAX_LAYERS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [NLW-1:0] n_layers,
    input  logic           load_ready,
    input  logic           layer_ready,
    output logic [2:0]     load,
    output logic           load_en,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [LIW-1:0] layer_idx
);
    localparam int HALF      = N_MACS / 2;
    localparam int NUM_PAIRS = N_MACS / 2;
    localparam int M1        = (TIMEOUT > FEED_LEN) ? TIMEOUT : FEED_LEN;
    localparam int M2        = (M1 > DRAIN_CYC) ? M1 : DRAIN_CYC;
    localparam int CNT_MAX   = (M2 > HALF) ? M2 : HALF;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WLO, S_WLO_WAIT, S_WHI, S_WHI_WAIT, S_FEED, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NLW-1:0] nlat_q, nlat_d;
    logic [LIW-1:0] layer_idx_q, layer_idx_d;
    logic [2:0]     load_q, load_d;
    logic           load_en_q, load_en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nlat_q      <= '0;
            layer_idx_q <= '0;
            load_q      <= 3'b000;
            load_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nlat_q      <= nlat_d;
            layer_idx_q <= layer_idx_d;
            load_q      <= load_d;
            load_en_q   <= load_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Timed states leave when cnt hits LEN-1; every entry clears cnt.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nlat_d      = nlat_q;
        layer_idx_d = layer_idx_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    cnt_d = '0;
                    if (n_layers != '0) begin
                        // Clamp so layer_idx can always reach the last layer.
                        nlat_d      = (n_layers > NLW'(MAX_LAYERS)) ? NLW'(MAX_LAYERS) : n_layers;
                        layer_idx_d = '0;
                        state_d     = S_WLO;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_WLO: begin
                    if (load_ready) begin
                        state_d = S_WLO_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WLO_WAIT: begin
                    if (cnt_q == CW'(HALF - 1)) begin
                        state_d = S_WHI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WHI: begin
                    if (layer_ready) begin
                        state_d = S_WHI_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WHI_WAIT: begin
                    if (cnt_q == CW'(NUM_PAIRS - 1)) begin
                        state_d = S_FEED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FEED: begin
                    if (cnt_q == CW'(FEED_LEN - 1)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                        cnt_d = '0;
                        if (NLW'(layer_idx_q) == nlat_q - NLW'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            layer_idx_d = layer_idx_q + LIW'(1);
                            state_d     = S_WLO;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so they are registered with it.
    always_comb begin
        load_d    = 3'b000;
        load_en_d = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            S_WLO:  load_d    = 3'b001;
            S_WHI:  load_d    = 3'b010;
            S_FEED: load_en_d = 1'b1;
            S_IDLE: busy_d    = 1'b0;
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            S_ERR: begin
                busy_d = 1'b0;
                err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign load      = load_q;
    assign load_en   = load_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign layer_idx = layer_idx_q;

endmodule

// File: tb/tb_systolic_load_sched.sv
// Directed bench for systolic_load_sched: a ready model answers each load
// one cycle late; a negedge monitor counts bursts and pulses.
module tb_systolic_load_sched;
    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [3:0] n_layers;
    logic       load_ready, layer_ready;
    logic [2:0] load;
    logic       load_en, busy, done, err;
    logic [2:0] layer_idx;

    systolic_load_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_layers(n_layers),
        .load_ready(load_ready), .layer_ready(layer_ready), .load(load), .load_en(load_en),
        .busy(busy), .done(done), .err(err), .layer_idx(layer_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         auto_rdy = 1'b1;
    bit         spur_lr  = 1'b0;
    logic [2:0] load_prev = 3'b000;
    logic       en_prev = 1'b0;
    int lo_cyc = 0, hi_cyc = 0, lo_b = 0, hi_b = 0, en_cnt = 0, en_b = 0, done_cnt = 0;
    int lidx_log [64];

    always @(negedge clk) begin
        load_ready  = auto_rdy && load == 3'b001 && load_prev == 3'b001;
        layer_ready = (auto_rdy && load == 3'b010 && load_prev == 3'b010) || spur_lr;
        if (load == 3'b001) begin
            lo_cyc++;
            if (load_prev != 3'b001) begin
                if (lo_b < 64) lidx_log[lo_b] = int'(layer_idx);
                lo_b++;
            end
        end
        if (load == 3'b010) begin
            hi_cyc++;
            if (load_prev != 3'b010) hi_b++;
        end
        if (load_en === 1'b1) begin
            en_cnt++;
            if (en_prev !== 1'b1) en_b++;
        end
        if (done === 1'b1) done_cnt++;
        load_prev = load;
        en_prev   = load_en;
    end

    int nchk = 0, nerr = 0;
    int b_lo, b_hi, b_lob, b_hib, b_en, b_enb, b_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_lo = lo_cyc; b_hi = hi_cyc; b_lob = lo_b; b_hib = hi_b;
        b_en = en_cnt; b_enb = en_b; b_done = done_cnt;
    endtask

    task automatic do_start(input int n, output int s);
        @(negedge clk); #1;
        start = 1'b1;
        n_layers = 4'(n);
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int s, input int bound, output int lat);
        int d0;
        d0  = done_cnt;
        lat = -1;
        repeat (bound) begin
            @(negedge clk); #1;
            if (done_cnt != d0) begin
                lat = cyc - s;
                break;
            end
        end
    endtask

    initial begin
        int s, lat;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; n_layers = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_load", 32'(load), 0);
        chk("rst_load_en", 32'(load_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_layer_idx", 32'(layer_idx), 0);
        @(negedge clk); rst_n = 1'b1;

        // single layer, prompt readies
        snap();
        do_start(1, s);
        chk("l1_busy", 32'(busy), 1);
        chk("l1_load_lo", 32'(load), 1);
        wait_done(s, 40, lat);
        chk("l1_latency", 32'(lat), 18);
        chk("l1_lo_cycles", 32'(lo_cyc - b_lo), 2);
        chk("l1_hi_cycles", 32'(hi_cyc - b_hi), 2);
        chk("l1_load_en", 32'(en_cnt - b_en), 4);
        chk("l1_en_bursts", 32'(en_b - b_enb), 1);
        chk("l1_busy_at_done", 32'(busy), 0);
        @(negedge clk); #1;
        chk("l1_done_single", 32'(done), 0);
        chk("l1_done_count", 32'(done_cnt - b_done), 1);

        // three layers
        snap();
        do_start(3, s);
        wait_done(s, 100, lat);
        chk("l3_latency", 32'(lat), 54);
        chk("l3_load_en", 32'(en_cnt - b_en), 12);
        chk("l3_lo_bursts", 32'(lo_b - b_lob), 3);
        chk("l3_hi_bursts", 32'(hi_b - b_hib), 3);
        chk("l3_lidx0", 32'(lidx_log[b_lob]), 0);
        chk("l3_lidx1", 32'(lidx_log[b_lob + 1]), 1);
        chk("l3_lidx2", 32'(lidx_log[b_lob + 2]), 2);
        repeat (3) @(negedge clk);
        #1;
        chk("l3_done_count", 32'(done_cnt - b_done), 1);
        chk("l3_layer_hold", 32'(layer_idx), 2);

        // timeout on load_ready
        auto_rdy = 1'b0;
        snap();
        do_start(1, s);
        lat = -1;
        repeat (40) begin
            @(negedge clk); #1;
            if (err === 1'b1) begin
                lat = cyc - s;
                break;
            end
        end
        chk("to_latency", 32'(lat), 15);
        chk("to_lo_cycles", 32'(lo_cyc - b_lo), 15);
        chk("to_load", 32'(load), 0);
        chk("to_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        #1;
        chk("to_err_sticky", 32'(err), 1);
        chk("to_no_done", 32'(done_cnt - b_done), 0);
        @(negedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("to_abort_err", 32'(err), 0);
        chk("to_abort_busy", 32'(busy), 0);
        auto_rdy = 1'b1;

        // abort mid-FEED after two load_en
        snap();
        do_start(1, s);
        repeat (40) begin
            @(negedge clk); #1;
            if (en_cnt - b_en >= 2) break;
        end
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("ab_load_en", 32'(load_en), 0);
        chk("ab_busy", 32'(busy), 0);
        repeat (25) @(negedge clk);
        #1;
        chk("ab_no_done", 32'(done_cnt - b_done), 0);
        chk("ab_en_count", 32'(en_cnt - b_en), 2);
        snap();
        do_start(1, s);
        wait_done(s, 40, lat);
        chk("ab_rerun_latency", 32'(lat), 18);
        chk("ab_rerun_en", 32'(en_cnt - b_en), 4);

        // zero layers
        snap();
        do_start(0, s);
        chk("z_done", 32'(done), 1);
        chk("z_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        #1;
        chk("z_done_count", 32'(done_cnt - b_done), 1);
        chk("z_no_load", 32'(lo_b - b_lob), 0);
        chk("z_no_en", 32'(en_cnt - b_en), 0);

        // start while busy, spurious layer_ready during FEED
        snap();
        do_start(1, s);
        repeat (3) @(negedge clk);
        #1; start = 1'b1; n_layers = 4'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            if (en_cnt - b_en >= 1) break;
        end
        spur_lr = 1'b1;
        @(negedge clk); #1; spur_lr = 1'b0;
        wait_done(s, 40, lat);
        chk("e_latency", 32'(lat), 18);
        chk("e_en", 32'(en_cnt - b_en), 4);
        chk("e_lo_bursts", 32'(lo_b - b_lob), 1);
        chk("e_hi_bursts", 32'(hi_b - b_hib), 1);
        chk("e_layer_idx", 32'(layer_idx), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
